// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2 : control FSM for the multi-cycle RV32I core.
// Sequences fetch, decode, execute, memory and writeback and drives every
// datapath mux select, write enable and the ALU opcode. Adds a memory ready
// handshake, all six branches, JALR/LUI/AUIPC, a trap state and a
// retired-instruction counter.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op, funct3, funct7  instruction fields from the instruction register
//   zero, lt, ltu       ALU flags (result==0, signed <, unsigned <)
//   mem_ready           memory access completes this cycle
//   mem_req, mem_write  memory request / write strobe
//   pc_write, ir_write  PC enable / IR+oldPC enable
//   reg_write           register file write enable
//   adr_src             address select (0 PC, 1 ALUOut)
//   alu_src_a/b         ALU operand selects
//   result_src          result mux select
//   imm_src             immediate format (combinational from op)
//   alu_control         ALU opcode
//   halted              FSM is in TRAP
//   instret             retired-instruction count (wraps)
module multicycle_ctrl_v2 #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_TRAP   = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             adr_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_UEXEC    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALRJ    = 4'd11,
        S_ALUWB    = 4'd12,
        S_BRANCH   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    // Destination of an unsupported instruction leaving DECODE.
    localparam state_t S_ILL = (ENABLE_TRAP != 0) ? S_TRAP : S_FETCH;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] instret_r;
    logic             ready_s;
    logic             taken_s;
    logic             retire_s;
    logic [1:0]       alu_op_s;
    logic             unused_s;

    // funct3/funct7 ALU decode; op[5] separates R-type from I-type so addi is never sub.
    function automatic logic [3:0] funct_alu(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (opc[5] && f7[5]) ? 4'b0001 : 4'b0000;
            3'b001:  code = 4'b0111;
            3'b010:  code = 4'b0101;
            3'b011:  code = 4'b0110;
            3'b100:  code = 4'b0100;
            3'b101:  code = f7[5] ? 4'b1001 : 4'b1000;
            3'b110:  code = 4'b0011;
            3'b111:  code = 4'b0010;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    assign ready_s  = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign instret  = instret_r;
    assign unused_s = ^{funct7[6], funct7[4:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter: bumps as a retiring state is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (retire_s && (next_state_s != state_r)) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // Branch condition from funct3 and the ALU flags.
    always_comb begin
        case (funct3)
            3'b000:  taken_s = zero;
            3'b001:  taken_s = ~zero;
            3'b100:  taken_s = lt;
            3'b101:  taken_s = ~lt;
            3'b110:  taken_s = ltu;
            3'b111:  taken_s = ~ltu;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_R:              next_state_s = S_EXECR;
                    OP_I:              next_state_s = S_EXECI;
                    OP_JAL:            next_state_s = S_JAL;
                    OP_JALR:           next_state_s = S_JALR;
                    OP_BRANCH:         next_state_s = ((funct3 == 3'b010) || (funct3 == 3'b011))
                                                      ? S_ILL : S_BRANCH;
                    OP_LUI, OP_AUIPC:  next_state_s = S_UEXEC;
                    default:           next_state_s = S_ILL;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    next_state_s = S_MEMREAD;
                end else if (op == OP_STORE) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMREAD:  next_state_s = ready_s ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = ready_s ? S_FETCH : S_MEMWRITE;
            S_EXECR:    next_state_s = S_ALUWB;
            S_EXECI:    next_state_s = S_ALUWB;
            S_UEXEC:    next_state_s = S_ALUWB;
            S_JAL:      next_state_s = S_ALUWB;
            S_JALR:     next_state_s = S_JALRJ;
            S_JALRJ:    next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            S_TRAP:     next_state_s = S_TRAP;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op_s   = 2'b00;
        halted     = 1'b0;
        retire_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready_s;
                pc_write   = ready_s;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire_s   = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire_s  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op_s  = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op_s  = 2'b10;
            end
            S_UEXEC: begin
                alu_src_a = op[5] ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
            end
            S_JAL, S_JALRJ: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire_s  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op_s  = 2'b01;
                pc_write  = taken_s;
                retire_s  = 1'b1;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // ALU opcode from the internal alu_op class.
    always_comb begin
        case (alu_op_s)
            2'b00:   alu_control = 4'b0000;
            2'b01:   alu_control = 4'b0001;
            2'b10:   alu_control = funct_alu(op, funct3, funct7);
            default: alu_control = 4'b0000;
        endcase
    end

    // Immediate format, purely from the opcode.
    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
            OP_STORE:               imm_src = 3'b001;
            OP_BRANCH:              imm_src = 3'b010;
            OP_JAL:                 imm_src = 3'b011;
            OP_LUI, OP_AUIPC:       imm_src = 3'b100;
            default:                imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl_v2;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWR = 5, P_ER = 6;
    localparam int P_EI = 7, P_UE = 8, P_JAL = 9, P_JR = 10, P_JRJ = 11, P_WB = 12;
    localparam int P_BR = 13, P_TRAP = 14;

    typedef struct packed {
        logic [3:0]  ph;
        logic [51:0] v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: handshake + trap, 32-bit counter. Instance 1: no handshake, no trap, 4-bit counter.
    logic       rst_v [2];
    logic [6:0] op_v [2];
    logic [2:0] f3_v [2];
    logic [6:0] f7_v [2];
    logic       zero_v [2];
    logic       lt_v [2];
    logic       ltu_v [2];
    logic       mem_ready_v [2];

    logic mem_req_0, pc_write_0, ir_write_0, reg_write_0, mem_write_0, adr_src_0, halted_0;
    logic [1:0] a_0, b_0, rs_0;
    logic [2:0] imm_0;
    logic [3:0] alu_0;
    logic [31:0] instret_0;
    logic mem_req_1, pc_write_1, ir_write_1, reg_write_1, mem_write_1, adr_src_1, halted_1;
    logic [1:0] a_1, b_1, rs_1;
    logic [2:0] imm_1;
    logic [3:0] alu_1;
    logic [3:0] instret_1;
    logic [51:0] obs0, obs1;

    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1), .ENABLE_TRAP(1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst_v[0]), .op(op_v[0]), .funct3(f3_v[0]), .funct7(f7_v[0]),
        .zero(zero_v[0]), .lt(lt_v[0]), .ltu(ltu_v[0]), .mem_ready(mem_ready_v[0]),
        .mem_req(mem_req_0), .pc_write(pc_write_0), .ir_write(ir_write_0),
        .reg_write(reg_write_0), .mem_write(mem_write_0), .adr_src(adr_src_0),
        .alu_src_a(a_0), .alu_src_b(b_0), .result_src(rs_0), .imm_src(imm_0),
        .alu_control(alu_0), .halted(halted_0), .instret(instret_0));

    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(0), .ENABLE_TRAP(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst_v[1]), .op(op_v[1]), .funct3(f3_v[1]), .funct7(f7_v[1]),
        .zero(zero_v[1]), .lt(lt_v[1]), .ltu(ltu_v[1]), .mem_ready(mem_ready_v[1]),
        .mem_req(mem_req_1), .pc_write(pc_write_1), .ir_write(ir_write_1),
        .reg_write(reg_write_1), .mem_write(mem_write_1), .adr_src(adr_src_1),
        .alu_src_a(a_1), .alu_src_b(b_1), .result_src(rs_1), .imm_src(imm_1),
        .alu_control(alu_1), .halted(halted_1), .instret(instret_1));

    assign obs0 = {mem_req_0, pc_write_0, ir_write_0, reg_write_0, mem_write_0, adr_src_0,
                   a_0, b_0, rs_0, imm_0, alu_0, halted_0, instret_0};
    assign obs1 = {mem_req_1, pc_write_1, ir_write_1, reg_write_1, mem_write_1, adr_src_1,
                   a_1, b_1, rs_1, imm_1, alu_1, halted_1, 28'd0, instret_1};

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] cnt_m [2];
    int tests = 0;
    int fails = 0;

    function automatic bit hs_en(input int inst);
        return inst == 0;
    endfunction

    function automatic bit trap_en(input int inst);
        return inst == 0;
    endfunction

    function automatic string ph_name(input logic [3:0] ph);
        case (ph)
            4'd0: return "FETCH";    4'd1: return "DECODE";  4'd2: return "MEMADR";
            4'd3: return "MEMREAD";  4'd4: return "MEMWB";   4'd5: return "MEMWRITE";
            4'd6: return "EXECR";    4'd7: return "EXECI";   4'd8: return "UEXEC";
            4'd9: return "JAL";      4'd10: return "JALR";   4'd11: return "JALRJ";
            4'd12: return "ALUWB";   4'd13: return "BRANCH"; 4'd14: return "TRAP";
            default: return "?";
        endcase
    endfunction

    // Reference ALU opcode for the R/I-type operation named by funct3/funct7.
    function automatic logic [3:0] alu_ref(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7);
        case (f3)
            3'd0: return (opc == OPR && f7[5]) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7[5] ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [2:0] imm_ref(input logic [6:0] opc);
        if (opc == LOAD || opc == OPI || opc == JALR) return 3'd0;
        if (opc == STORE) return 3'd1;
        if (opc == BR) return 3'd2;
        if (opc == JAL) return 3'd3;
        if (opc == LUI || opc == AUIPC) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic taken_ref(input logic [2:0] f3, input logic z, input logic l,
                                       input logic lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Expected output word for one cycle of a given phase.
    function automatic logic [51:0] exp_out(input int ph, input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic z, input logic l,
                                            input logic lu, input logic rdy, input logic [31:0] cnt);
        logic mreq, pcw, irw, rw, mw, adr, hlt;
        logic [1:0] a, b, rs;
        logic [3:0] alu;
        mreq = 1'b0; pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0; adr = 1'b0; hlt = 1'b0;
        a = 2'd0; b = 2'd0; rs = 2'd0; alu = 4'd0;
        case (ph)
            P_F:    begin mreq = 1'b1; b = 2'd2; rs = 2'd2; irw = rdy; pcw = rdy; end
            P_D:    begin a = 2'd1; b = 2'd1; end
            P_MA:   begin a = 2'd2; b = 2'd1; end
            P_MR:   begin mreq = 1'b1; adr = 1'b1; end
            P_MW:   begin rs = 2'd1; rw = 1'b1; end
            P_MWR:  begin mreq = 1'b1; adr = 1'b1; mw = 1'b1; end
            P_ER:   begin a = 2'd2; alu = alu_ref(opc, f3, f7); end
            P_EI:   begin a = 2'd2; b = 2'd1; alu = alu_ref(opc, f3, f7); end
            P_UE:   begin a = (opc == LUI) ? 2'd3 : 2'd1; b = 2'd1; end
            P_JAL:  begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
            P_JR:   begin a = 2'd2; b = 2'd1; end
            P_JRJ:  begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
            P_WB:   begin rw = 1'b1; end
            P_BR:   begin a = 2'd2; alu = 4'd1; pcw = taken_ref(f3, z, l, lu); end
            P_TRAP: begin hlt = 1'b1; end
            default: begin hlt = 1'b0; end
        endcase
        return {mreq, pcw, irw, rw, mw, adr, a, b, rs, imm_ref(opc), alu, hlt, cnt};
    endfunction

    task automatic check(input int inst, input exp_t e, input logic [51:0] act);
        tests++;
        if (act !== e.v) begin
            fails++;
            $display("FAIL inst%0d %s at %0t: got %h expected %h", inst, ph_name(e.ph), $time,
                     act, e.v);
        end
    endtask

    // Monitor: compares each presented cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, e, obs0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, e, obs1);
        end
    end

    task automatic cycle(input int inst, input int ph, input logic rdy);
        exp_t e;
        mem_ready_v[inst] = rdy;
        e.ph = 4'(ph);
        e.v = exp_out(ph, op_v[inst], f3_v[inst], f7_v[inst], zero_v[inst], lt_v[inst],
                      ltu_v[inst], hs_en(inst) ? rdy : 1'b1, cnt_m[inst]);
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bump(input int inst);
        cnt_m[inst] = (inst == 0) ? cnt_m[inst] + 32'd1 : ((cnt_m[inst] + 32'd1) & 32'hF);
    endtask

    // Phase that waits for mem_ready: nwait low cycles, then ready.
    task automatic wait_phase(input int inst, input int ph, input int nwait);
        int i = 0;
        logic rdy;
        forever begin
            rdy = (i >= nwait);
            cycle(inst, ph, rdy);
            if (rdy || !hs_en(inst)) break;
            i++;
        end
    endtask

    task automatic rnd_cycle(input int inst, input int ph);
        cycle(inst, ph, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input int inst);
        exp_t e;
        rst_v[inst] = 1'b1;
        mem_ready_v[inst] = 1'b0;
        cnt_m[inst] = 32'd0;
        if (hs_en(inst)) begin
            e.ph = 4'(P_F);
            e.v = exp_out(P_F, op_v[inst], f3_v[inst], f7_v[inst], zero_v[inst], lt_v[inst],
                          ltu_v[inst], 1'b0, 32'd0);
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        rst_v[inst] = 1'b0;
    endtask

    task automatic run_instr(input int inst, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic l, input logic lu,
                             input int fw, input int mw, input bit abort);
        op_v[inst] = opc; f3_v[inst] = f3; f7_v[inst] = f7;
        zero_v[inst] = z; lt_v[inst] = l; ltu_v[inst] = lu;
        wait_phase(inst, P_F, fw);
        rnd_cycle(inst, P_D);
        if (opc == LOAD) begin
            rnd_cycle(inst, P_MA);
            wait_phase(inst, P_MR, mw);
            rnd_cycle(inst, P_MW);
            bump(inst);
        end else if (opc == STORE) begin
            rnd_cycle(inst, P_MA);
            if (abort) begin
                cycle(inst, P_MWR, 1'b0);
                do_reset(inst);
                return;
            end
            wait_phase(inst, P_MWR, mw);
            bump(inst);
        end else if (opc == OPR || opc == OPI || opc == LUI || opc == AUIPC || opc == JAL) begin
            rnd_cycle(inst, (opc == OPR) ? P_ER : (opc == OPI) ? P_EI : (opc == JAL) ? P_JAL : P_UE);
            rnd_cycle(inst, P_WB);
            bump(inst);
        end else if (opc == JALR) begin
            rnd_cycle(inst, P_JR);
            rnd_cycle(inst, P_JRJ);
            rnd_cycle(inst, P_WB);
            bump(inst);
        end else if (opc == BR && f3 != 3'd2 && f3 != 3'd3) begin
            rnd_cycle(inst, P_BR);
            bump(inst);
        end else if (trap_en(inst)) begin
            repeat (20) rnd_cycle(inst, P_TRAP);
            do_reset(inst);
        end
    endtask

    task automatic run_random(input int inst);
        logic [6:0] opc;
        logic [6:0] f7;
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0: opc = LOAD;  1: opc = STORE; 2: opc = OPR;   3: opc = OPI; 4: opc = JAL;
            5: opc = JALR;  6: opc = BR;    7: opc = LUI;   8: opc = AUIPC;
            default: opc = 7'($urandom);
        endcase
        k = $urandom_range(0, 2);
        f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
        run_instr(inst, opc, 3'($urandom), f7, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; op_v[i] = 7'd0; f3_v[i] = 3'd0; f7_v[i] = 7'd0;
            zero_v[i] = 1'b0; lt_v[i] = 1'b0; ltu_v[i] = 1'b0; mem_ready_v[i] = 1'b0;
            cnt_m[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Instance 0: handshake and trap enabled.
        do_reset(0);
        run_instr(0, LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0);
        run_instr(0, BR, 3'd5, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, BR, 3'd5, 7'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(0, OPI, 3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, OPR, 3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, OPI, 3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, OPR, 3'd5, 7'h00, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        run_instr(0, JALR, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, STORE, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0);
        run_instr(0, JAL, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, LUI, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, AUIPC, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int f = 0; f < 8; f++) begin
            if (f != 2 && f != 3) begin
                run_instr(0, BR, 3'(f), 7'h00, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
                run_instr(0, BR, 3'(f), 7'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            end
        end
        run_instr(0, STORE, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(0, OPR, 3'd7, 7'h00, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
        repeat (60) run_random(0);
        run_instr(0, 7'b1111111, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, BR, 3'd3, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(0, OPI, 3'd1, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        // Instance 1: mem_ready ignored, illegal returns to FETCH, 4-bit wrapping counter.
        do_reset(1);
        run_instr(1, LUI, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(1, 7'b1111111, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(1, BR, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(1, LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0);
        run_instr(1, STORE, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 2, 2, 1'b0);
        repeat (40) run_random(1);
        @(posedge clk);
        #1;
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
